// File: rtl/contador_iteraciones_param.sv
// ============================================================================
//  Module   : contador_iteraciones_param
//  Purpose  : Parametrised iteration counter sequencing multi-cycle shift/add
//             algorithms; counts down to 0 or up to a latched limit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_iteraciones_param #(
   parameter int ANCHO         = 5,
   parameter int VALOR_DEFECTO = 16,
   parameter int AUTO_RECARGA  = 0
) (
   input  logic             reloj,
   input  logic             reset_n,
   input  logic             carga,
   input  logic             usar_valor,
   input  logic [ANCHO-1:0] valor_carga,
   input  logic             modo,
   input  logic             habilitar,
   output logic [ANCHO-1:0] cuenta,
   output logic             ocupado,
   output logic             fin_contador,
   output logic             pulso_fin
);

   localparam logic [ANCHO-1:0] C_DEFECTO = ANCHO'(VALOR_DEFECTO);

   typedef enum logic [1:0] {
      REPOSO   = 2'd0,
      CONTANDO = 2'd1,
      FIN      = 2'd2
   } estado_t;

   estado_t          estado_q, estado_d;
   logic [ANCHO-1:0] cuenta_q, cuenta_d;
   logic [ANCHO-1:0] limite_q, limite_d;
   logic             modo_q, modo_d;
   logic             pulso_q, pulso_d;
   logic             ocupado_q, ocupado_d;
   logic             fin_q, fin_d;

   logic [ANCHO-1:0] w_limite_carga;
   logic [ANCHO-1:0] w_terminal;
   logic [ANCHO-1:0] w_siguiente;

   assign w_limite_carga = usar_valor ? valor_carga : C_DEFECTO;
   assign w_terminal     = modo_q ? limite_q : '0;
   assign w_siguiente    = modo_q ? (cuenta_q + 1'b1) : (cuenta_q - 1'b1);

   always_comb begin
      estado_d = estado_q;
      cuenta_d = cuenta_q;
      limite_d = limite_q;
      modo_d   = modo_q;
      pulso_d  = 1'b0;

      if (carga) begin
         limite_d = w_limite_carga;
         modo_d   = modo;
         cuenta_d = modo ? '0 : w_limite_carga;
         // A zero limit is already terminal in either mode.
         if (w_limite_carga == '0) begin
            estado_d = FIN;
            pulso_d  = 1'b1;
         end else begin
            estado_d = CONTANDO;
         end
      end else begin
         case (estado_q)
            CONTANDO: begin
               if (habilitar) begin
                  cuenta_d = w_siguiente;
                  if (w_siguiente == w_terminal) begin
                     estado_d = FIN;
                     pulso_d  = 1'b1;
                  end
               end
            end
            FIN: begin
               // A zero latched limit stays parked so the count cannot wrap.
               if ((AUTO_RECARGA != 0) && (limite_q != '0)) begin
                  cuenta_d = modo_q ? '0 : limite_q;
                  estado_d = CONTANDO;
               end
            end
            default: begin
               estado_d = estado_q;
            end
         endcase
      end

      ocupado_d = (estado_d == CONTANDO);
      fin_d     = (estado_d == FIN);
   end

   always_ff @(negedge reloj or negedge reset_n) begin
      if (!reset_n) begin
         estado_q  <= REPOSO;
         cuenta_q  <= '0;
         limite_q  <= C_DEFECTO;
         modo_q    <= 1'b0;
         pulso_q   <= 1'b0;
         ocupado_q <= 1'b0;
         fin_q     <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         cuenta_q  <= cuenta_d;
         limite_q  <= limite_d;
         modo_q    <= modo_d;
         pulso_q   <= pulso_d;
         ocupado_q <= ocupado_d;
         fin_q     <= fin_d;
      end
   end

   assign cuenta       = cuenta_q;
   assign ocupado      = ocupado_q;
   assign fin_contador = fin_q;
   assign pulso_fin    = pulso_q;

endmodule

`default_nettype wire

// File: tb/tb_contador_iteraciones_param.sv
// ============================================================================
//  Module   : tb_contador_iteraciones_param
//  Purpose  : Directed self-checking bench for contador_iteraciones_param.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_contador_iteraciones_param;

   logic       reloj;
   logic       reset_n;
   logic       carga;
   logic       usar_valor;
   logic [4:0] valor_carga;
   logic       modo;
   logic       habilitar;

   logic [4:0] cuenta_a;
   logic       ocupado_a, fin_a, pulso_a;
   logic [3:0] cuenta_b;
   logic       ocupado_b, fin_b, pulso_b;

   int vectores = 0;
   int errores  = 0;

   contador_iteraciones_param #(
      .ANCHO(5), .VALOR_DEFECTO(16), .AUTO_RECARGA(0)
   ) u_dut_a (
      .reloj(reloj), .reset_n(reset_n), .carga(carga), .usar_valor(usar_valor),
      .valor_carga(valor_carga), .modo(modo), .habilitar(habilitar),
      .cuenta(cuenta_a), .ocupado(ocupado_a), .fin_contador(fin_a), .pulso_fin(pulso_a)
   );

   contador_iteraciones_param #(
      .ANCHO(4), .VALOR_DEFECTO(4), .AUTO_RECARGA(1)
   ) u_dut_b (
      .reloj(reloj), .reset_n(reset_n), .carga(carga), .usar_valor(usar_valor),
      .valor_carga(valor_carga[3:0]), .modo(modo), .habilitar(habilitar),
      .cuenta(cuenta_b), .ocupado(ocupado_b), .fin_contador(fin_b), .pulso_fin(pulso_b)
   );

   initial begin
      reloj = 1'b1;
      forever #5 reloj = ~reloj;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectores++;
      assert (obs === exp) else begin
         errores++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next active (falling) edge.
   task automatic paso();
      @(negedge reloj);
      #1;
   endtask

   task automatic chk_a(input string tag, input int c, input logic o, input logic f, input logic p);
      chk({tag, ".cuenta"},  32'(cuenta_a),  32'(c));
      chk({tag, ".ocupado"}, 32'(ocupado_a), 32'(o));
      chk({tag, ".fin"},     32'(fin_a),     32'(f));
      chk({tag, ".pulso"},   32'(pulso_a),   32'(p));
   endtask

   initial begin
      int e;
      logic efin;

      reset_n = 1'b0; carga = 1'b0; usar_valor = 1'b0;
      valor_carga = 5'd0; modo = 1'b0; habilitar = 1'b0;
      #3;
      chk_a("reset", 0, 1'b0, 1'b0, 1'b0);
      paso();
      reset_n = 1'b1;
      habilitar = 1'b1;
      paso();
      chk_a("reposo_hab", 0, 1'b0, 1'b0, 1'b0);

      // Default down count 16 -> 0
      carga = 1'b1; usar_valor = 1'b0; modo = 1'b0; habilitar = 1'b0;
      paso();
      chk_a("down_load", 16, 1'b1, 1'b0, 1'b0);
      carga = 1'b0; habilitar = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         paso();
         chk_a("down_step", 16 - i, (i != 16), (i == 16), (i == 16));
      end
      paso();
      chk_a("down_hold", 0, 1'b0, 1'b1, 1'b0);

      // Up count to runtime limit 5 with alternating enable
      valor_carga = 5'd5; usar_valor = 1'b1; modo = 1'b1; carga = 1'b1; habilitar = 1'b0;
      paso();
      chk_a("up_load", 0, 1'b1, 1'b0, 1'b0);
      carga = 1'b0; modo = 1'b0; usar_valor = 1'b0; valor_carga = 5'd31;
      e = 0;
      for (int k = 0; k < 10; k++) begin
         logic p;
         habilitar = ((k % 2) == 0);
         p = 1'b0;
         if (habilitar && e < 5) begin
            e = e + 1;
            p = (e == 5);
         end
         paso();
         chk_a("up_step", e, (e != 5), (e == 5), p);
      end

      // Zero limit with carga and habilitar together
      valor_carga = 5'd0; usar_valor = 1'b1; modo = 1'b0; carga = 1'b1; habilitar = 1'b1;
      paso();
      chk_a("zero_load", 0, 1'b0, 1'b1, 1'b1);
      carga = 1'b0;
      paso();
      chk_a("zero_after", 0, 1'b0, 1'b1, 1'b0);

      // Restart mid-count
      carga = 1'b1; usar_valor = 1'b0; habilitar = 1'b1;
      paso();
      chk_a("rst_load", 16, 1'b1, 1'b0, 1'b0);
      carga = 1'b0;
      repeat (7) paso();
      chk_a("rst_at9", 9, 1'b1, 1'b0, 1'b0);
      carga = 1'b1; usar_valor = 1'b1; valor_carga = 5'd3;
      paso();
      chk_a("rst_reload", 3, 1'b1, 1'b0, 1'b0);
      carga = 1'b0;
      paso();
      chk_a("rst_s1", 2, 1'b1, 1'b0, 1'b0);
      paso();
      chk_a("rst_s2", 1, 1'b1, 1'b0, 1'b0);
      paso();
      chk_a("rst_s3", 0, 1'b0, 1'b1, 1'b1);

      // Asynchronous reset mid-count
      carga = 1'b1; usar_valor = 1'b0;
      paso();
      carga = 1'b0;
      repeat (9) paso();
      chk_a("async_at7", 7, 1'b1, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk_a("async_clear", 0, 1'b0, 1'b0, 1'b0);
      paso();
      chk_a("async_held", 0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         paso();
         chk_a("async_reposo", 0, 1'b0, 1'b0, 1'b0);
      end

      // Auto-reload instance: default limit 4, down mode
      carga = 1'b1; usar_valor = 1'b0; modo = 1'b0; habilitar = 1'b1;
      paso();
      chk("auto_load.cuenta", 32'(cuenta_b), 32'd4);
      chk("auto_load.ocupado", 32'(ocupado_b), 32'd1);
      carga = 1'b0;
      e = 4; efin = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (efin) e = 4;
         else      e = e - 1;
         efin = (e == 0);
         paso();
         chk("auto.cuenta",  32'(cuenta_b),  32'(e));
         chk("auto.fin",     32'(fin_b),     32'(efin));
         chk("auto.pulso",   32'(pulso_b),   32'(efin));
         chk("auto.ocupado", 32'(ocupado_b), 32'(!efin));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectores, errores);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/contador_iteraciones_param.md
Name: contador_iteraciones_param

Overview:
Parametrised iteration counter that sequences multi-cycle shift/add algorithms such as BCD-to-binary, binary-to-BCD and shift-add multiply in the calculator datapath. It loads a default or runtime iteration count and steps down to 0, or up to the limit, only when `habilitar` is high. It reports the current count, a busy level, a terminal level and a one-cycle terminal pulse. It optionally reloads itself for back-to-back operations.

Parameters:
ANCHO, 5, width of the count and limit, in bits.
VALOR_DEFECTO, 16, iteration limit used when `usar_valor`=0; must fit in ANCHO bits.
AUTO_RECARGA, 0, 1 = reload the latched limit automatically one cycle after reaching the terminal count.

Ports:
reloj  input  1  clock; all state updates on the falling edge.
reset_n  input  1  asynchronous reset, active low.
carga  input  1  start or restart: latch the limit and mode, then begin counting.
usar_valor  input  1  at `carga`: 1 = use `valor_carga`, 0 = use VALOR_DEFECTO.
valor_carga  input  ANCHO  runtime iteration limit.
modo  input  1  at `carga`: 0 = count down from limit to 0, 1 = count up from 0 to limit.
habilitar  input  1  advance one step on this edge while counting.
cuenta  output  ANCHO  current count value.
ocupado  output  1  high while in CONTANDO.
fin_contador  output  1  high while in FIN.
pulso_fin  output  1  one-cycle pulse on the edge the terminal count is reached.

Behaviour:
- Reset:
  - reset_n=0 forces, asynchronously: state REPOSO, cuenta=0, ocupado=0, fin_contador=0, pulso_fin=0, latched limit=VALOR_DEFECTO, latched modo=0.
  - Release of reset is sampled on the next falling edge.
  - Reset mid-count aborts the operation; no pulse is produced.
- Internal registers:
  - `limite` (ANCHO) and `modo_r`, written only on `carga`.
  - Terminal value T = 0 when modo_r=0, T = limite when modo_r=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States:
  - REPOSO: ocupado=0, fin_contador=0; cuenta holds its value; `habilitar` is ignored.
  - CONTANDO: ocupado=1.
    - If habilitar=1: cuenta steps by -1 (modo_r=0) or +1 (modo_r=1).
    - If the new value equals T: go to FIN and set pulso_fin=1 on the same edge.
    - If habilitar=0: hold the count, no state change.
  - FIN: fin_contador=1, ocupado=0, cuenta=T.
    - AUTO_RECARGA=0: stay in FIN until `carga`.
    - AUTO_RECARGA=1: on the next edge, reload cuenta with the start value from the latched limite/modo_r and go to CONTANDO. fin_contador is high for exactly one cycle.
- `carga` (any state, including CONTANDO and FIN):
  - Latch limite = (usar_valor ? valor_carga : VALOR_DEFECTO) and modo_r = modo.
  - Set cuenta = limite (down) or 0 (up).
  - Go to CONTANDO; pulso_fin=0.
- Priority: reset_n > carga > habilitar. `carga` and `habilitar` together on one edge loads only; the first step happens on the next enabled edge.
- Zero limit: `carga` with an effective limit of 0 gives cuenta=0 and goes directly to FIN with pulso_fin=1 on the load edge; `ocupado` is never asserted.
- Number of enabled steps from load to FIN is always exactly `limite`, in both modes.
- `cuenta` never wraps: stepping stops at T, and `habilitar` in FIN or REPOSO has no effect.
- `modo`, `usar_valor` and `valor_carga` are don't-care except on the `carga` edge.
- pulso_fin is high for exactly one cycle per terminal event, including each auto-reload round.

Test Plan:
- Default down count: reset, carga=1 with usar_valor=0, modo=0, then habilitar=1 continuously -> cuenta 16,15,…,0; pulso_fin high once on the 16th enabled edge; fin_contador stays 1; ocupado falls on the same edge.
- Up count with runtime limit: valor_carga=5, usar_valor=1, modo=1, carga, then habilitar toggling 1,0,1,… -> cuenta 0→5 after exactly 5 enabled edges; holds on habilitar=0 edges; pulso_fin at count 5.
- Zero limit and priority: valor_carga=0, usar_valor=1, carga together with habilitar=1 -> FIN on the load edge, pulso_fin=1, ocupado never 1, cuenta=0.
- Restart mid-count: load 16 down, step to 9, assert carga with valor_carga=3 -> cuenta=3, still CONTANDO, no pulso_fin; reaches 0 after 3 more enabled edges.
- Auto-reload (AUTO_RECARGA=1, ANCHO=4, VALOR_DEFECTO=4): load, habilitar held high -> periodic pattern 4,3,2,1,0(fin, pulse),4,3,…; pulso_fin once per round; fin_contador one cycle wide.
- Async reset mid-count: assert reset_n=0 between clock edges at cuenta=7 -> outputs clear immediately without a clock edge; no pulso_fin; after release, habilitar alone leaves the block in REPOSO.
